download_ctrl: RTL and testbench

DOWNLOAD_CTRL -- requirements
Module: download_ctrl

---
 rtl/download_ctrl_pkg.sv | 23 ++
 rtl/dl_reset_stretch.sv | 36 +++
 rtl/download_ctrl.sv | 168 ++++++++++++++++
 tb/tb_download_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/download_ctrl_pkg.sv
// Shared types and constants for the HPS ROM/DIP download controller.
package download_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROM  = 2'd1,
    ST_PEND = 2'd2,
    ST_HOLD = 2'd3
  } dl_state_e;

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_MODE = 8'd1;
  localparam logic [7:0] IDX_DIP  = 8'd254;

  localparam logic [1:0] GAME_BLOCKADE = 2'd0;
  localparam logic [1:0] GAME_COMOTION = 2'd1;
  localparam logic [1:0] GAME_HUSTLE   = 2'd2;
  localparam logic [1:0] GAME_BLASTO   = 2'd3;

  // Accepted-byte counter stops one past the last 14-bit address.
  localparam logic [14:0] ROM_COUNT_MAX = 15'd16384;

endpackage

// File: rtl/dl_reset_stretch.sv
// Loadable down-counter that times the core reset stretch after a ROM download.
module dl_reset_stretch #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(CYCLES + 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(CYCLES);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done during the last counted cycle so the owner leaves on the next edge.
  assign done_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/download_ctrl.sv
// HPS download controller: ROM write port with back-pressure, game mode, DIP bytes.
// Optional ROM checksum/byte count is built when DOWNLOAD_CTRL_CHECKSUM_EN is defined.
module download_ctrl
  import download_ctrl_pkg::*;
#(
  parameter int unsigned ROM_SIZE    = 16384,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [13:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  input  logic        dn_ready,
  output logic [1:0]  game_mode,
  output logic [63:0] dip_sw,
  output logic        core_reset,
  output logic        rom_error,
  output logic [7:0]  rom_sum,
  output logic [14:0] rom_count,
  output dl_state_e   dbg_state
);

  localparam logic [24:0] ROM_LIMIT = 25'(ROM_SIZE);

  dl_state_e       state_q, state_d;
  logic            dn_wr_q, dn_wr_d;
  logic [13:0]     dn_addr_q;
  logic [7:0]      dn_data_q;
  logic [1:0]      game_mode_q;
  logic [7:0][7:0] dip_q;
  logic            rom_error_q;
  logic            rom_wr, accept, err_set, rom_entry, hold_load, hold_done;

  assign rom_wr = ioctl_wr && (ioctl_index == IDX_ROM);
  assign accept = (state_q == ST_ROM) && ioctl_download && rom_wr && (ioctl_addr < ROM_LIMIT);

  // Handshake: a dn_wr pulse is one cycle and is only issued once dn_ready has
  // been sampled high; until then ioctl_wait holds the HPS off.
  always_comb begin
    state_d   = state_q;
    dn_wr_d   = 1'b0;
    err_set   = 1'b0;
    rom_entry = 1'b0;
    hold_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ioctl_download && (ioctl_index == IDX_ROM)) begin
          state_d   = ST_ROM;
          rom_entry = 1'b1;
        end
      end
      ST_ROM: begin
        if (!ioctl_download) begin
          state_d   = ST_HOLD;
          hold_load = 1'b1;
        end else if (rom_wr) begin
          if (!accept) begin
            err_set = 1'b1;
          end else if (dn_ready) begin
            dn_wr_d = 1'b1;
          end else begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (ioctl_wr) begin
          err_set = 1'b1;
        end
        // Download end is picked up in ROM once the pending byte has gone out.
        if (dn_ready) begin
          dn_wr_d = 1'b1;
          state_d = ST_ROM;
        end
      end
      ST_HOLD: begin
        if (ioctl_download && (ioctl_index == IDX_ROM)) begin
          state_d   = ST_ROM;
          rom_entry = 1'b1;
        end else if (hold_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dn_wr_q     <= 1'b0;
      dn_addr_q   <= '0;
      dn_data_q   <= '0;
      game_mode_q <= GAME_BLOCKADE;
      dip_q       <= '0;
      rom_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dn_wr_q <= dn_wr_d;
      if (accept) begin
        dn_addr_q <= ioctl_addr[13:0];
        dn_data_q <= ioctl_dout;
      end
      if (rom_entry) begin
        rom_error_q <= 1'b0;
      end else if (err_set) begin
        rom_error_q <= 1'b1;
      end
      if (ioctl_wr && (ioctl_index == IDX_MODE)) begin
        game_mode_q <= ioctl_dout[1:0];
      end
      if (ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0)) begin
        dip_q[ioctl_addr[2:0]] <= ioctl_dout;
      end
    end
  end

  dl_reset_stretch #(
    .CYCLES (HOLD_CYCLES)
  ) u_stretch (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (hold_load),
    .en_i    (state_q == ST_HOLD),
    .done_o  (hold_done)
  );

`ifdef DOWNLOAD_CTRL_CHECKSUM_EN
  logic [7:0]  sum_q;
  logic [14:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || rom_entry) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (dn_wr_q) begin
      sum_q <= sum_q + dn_data_q;
      if (cnt_q < ROM_COUNT_MAX) begin
        cnt_q <= cnt_q + 15'd1;
      end
    end
  end

  assign rom_sum   = sum_q;
  assign rom_count = cnt_q;
`else
  assign rom_sum   = '0;
  assign rom_count = '0;
`endif

  assign ioctl_wait = (state_q == ST_PEND) || (accept && !dn_ready);
  assign dn_wr      = dn_wr_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign game_mode  = game_mode_q;
  assign dip_sw     = dip_q;
  assign rom_error  = rom_error_q;
  assign core_reset = reset || (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_download_ctrl.sv
// Self-checking bench for download_ctrl: ROM writes are scoreboarded against dn_wr.
module tb_download_ctrl;
  import download_ctrl_pkg::*;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        dn_ready = 1'b1;
  logic        ioctl_wait, dn_wr, core_reset, rom_error;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data, rom_sum;
  logic [1:0]  game_mode;
  logic [63:0] dip_sw;
  logic [14:0] rom_count;
  dl_state_e   dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [21:0] exp_q[$];
  logic [7:0]  sb_sum = '0;
  int          sb_cnt = 0;
  logic [7:0]  dip_m [8];

  download_ctrl #(.ROM_SIZE(16384), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .dn_ready(dn_ready), .game_mode(game_mode), .dip_sw(dip_sw), .core_reset(core_reset),
    .rom_error(rom_error), .rom_sum(rom_sum), .rom_count(rom_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_sum();
`ifdef DOWNLOAD_CTRL_CHECKSUM_EN
    return 64'(sb_sum);
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] exp_cnt();
`ifdef DOWNLOAD_CTRL_CHECKSUM_EN
    return 64'(sb_cnt);
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] exp_dip();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = dip_m[i];
    return v;
  endfunction

  // scoreboard: every dn_wr pulse must match the oldest accepted ROM byte
  always @(negedge clk) begin
    if (!reset && dn_wr) begin
      if (exp_q.size() == 0) check("dn_wr_spurious", 64'(dn_wr), 64'd0);
      else check("dn_wr_payload", 64'({dn_addr, dn_data}), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hps_wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data,
                        input int stall, input bit rom_ok);
    int n;
    @(posedge clk); #1;
    ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data; ioctl_wr = 1'b1;
    if (stall > 0) dn_ready = 1'b0;
    if (rom_ok) begin
      exp_q.push_back({addr[13:0], data});
      sb_sum += data;
      sb_cnt++;
    end
    @(negedge clk);
    if (stall > 0) check("wait_accept", 64'(ioctl_wait), 64'd1);
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    for (int i = 1; i < stall; i++) begin
      @(negedge clk);
      check("wait_pend", 64'(ioctl_wait), 64'd1);
      @(posedge clk); #1;
    end
    dn_ready = 1'b1;
    if (stall > 0) begin
      n = 0;
      @(negedge clk);
      while (ioctl_wait && n < 20) begin n++; @(negedge clk); end
      check("wait_release", 64'(ioctl_wait), 64'd0);
    end
  endtask

  task automatic start_dl();
    @(posedge clk); #1;
    ioctl_download = 1'b1; ioctl_index = IDX_ROM;
    sb_sum = '0; sb_cnt = 0;
    cyc(1);
  endtask

  task automatic end_dl();
    int n;
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    n = 0;
    @(negedge clk);
    while (core_reset && n < 100) begin n++; @(negedge clk); end
    check("hold_len", 64'(n), 64'(HOLD));
    check("hold_release", 64'(core_reset), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dn_wr"}, 64'(dn_wr), 64'd0);
    check({tag, "_dn_addr"}, 64'(dn_addr), 64'd0);
    check({tag, "_dn_data"}, 64'(dn_data), 64'd0);
    check({tag, "_wait"}, 64'(ioctl_wait), 64'd0);
    check({tag, "_mode"}, 64'(game_mode), 64'd0);
    check({tag, "_dip"}, dip_sw, 64'd0);
    check({tag, "_err"}, 64'(rom_error), 64'd0);
    check({tag, "_sum"}, 64'(rom_sum), 64'd0);
    check({tag, "_cnt"}, 64'(rom_count), 64'd0);
    check({tag, "_core_rst"}, 64'(core_reset), 64'd1);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dip_m[i] = '0;

    // reset values
    cyc(3);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_core_rst", 64'(core_reset), 64'd0);

    // 4-byte download, dn_ready always high
    start_dl();
    check("rom_core_rst", 64'(core_reset), 64'd1);
    hps_wr(IDX_ROM, 25'd0, 8'hA5, 0, 1);
    hps_wr(IDX_ROM, 25'd1, 8'h01, 0, 1);
    hps_wr(IDX_ROM, 25'd2, 8'hFF, 0, 1);
    hps_wr(IDX_ROM, 25'd3, 8'h10, 0, 1);
    cyc(3);
    check("sum4", 64'(rom_sum), exp_sum());
    check("cnt4", 64'(rom_count), exp_cnt());
    check("err4", 64'(rom_error), 64'd0);
    end_dl();

    // back-pressure on the second byte, then out-of-range and top-address writes
    start_dl();
    hps_wr(IDX_ROM, 25'd10, 8'h11, 0, 1);
    hps_wr(IDX_ROM, 25'd11, 8'h22, 3, 1);
    hps_wr(IDX_ROM, 25'd12, 8'h33, 0, 1);
    hps_wr(IDX_ROM, 25'd16384, 8'h99, 0, 0);
    cyc(1);
    check("oob_err", 64'(rom_error), 64'd1);
    hps_wr(IDX_ROM, 25'd16383, 8'h44, 0, 1);
    cyc(3);
    check("sum_stall", 64'(rom_sum), exp_sum());
    check("cnt_stall", 64'(rom_count), exp_cnt());
    // download restarted during HOLD returns to ROM and restarts the hold
    @(posedge clk); #1 ioctl_download = 1'b0;
    cyc(6);
    check("hold_state", 64'(dbg_state), 64'(ST_HOLD));
    check("err_sticky", 64'(rom_error), 64'd1);
    ioctl_download = 1'b1;
    sb_sum = '0; sb_cnt = 0;
    cyc(1);
    check("restart_state", 64'(dbg_state), 64'(ST_ROM));
    check("restart_err_clr", 64'(rom_error), 64'd0);
    end_dl();

    // game mode and DIP bytes
    hps_wr(IDX_MODE, 25'd0, 8'h03, 0, 0);
    hps_wr(IDX_DIP, 25'd0, 8'h1C, 0, 0);  dip_m[0] = 8'h1C;
    hps_wr(IDX_DIP, 25'd9, 8'hFF, 0, 0);
    hps_wr(IDX_DIP, 25'd5, 8'h77, 0, 0);  dip_m[5] = 8'h77;
    hps_wr(8'd7, 25'd0, 8'h00, 0, 0);
    cyc(1);
    check("game_mode", 64'(game_mode), 64'd3);
    check("dip_sw", dip_sw, exp_dip());
    hps_wr(IDX_MODE, 25'd0, 8'hFE, 0, 0);
    cyc(1);
    check("game_mode_last", 64'(game_mode), 64'd2);

    // download ends and a second write arrives while a byte is pending
    start_dl();
    @(posedge clk); #1;
    ioctl_addr = 25'd40; ioctl_dout = 8'h5A; ioctl_wr = 1'b1; dn_ready = 1'b0;
    exp_q.push_back({14'd40, 8'h5A}); sb_sum += 8'h5A; sb_cnt++;
    @(posedge clk); #1 ioctl_wr = 1'b0;
    @(posedge clk); #1 ioctl_wr = 1'b1; ioctl_addr = 25'd41; ioctl_dout = 8'hEE;
    @(posedge clk); #1 ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk);
    check("pend_wait", 64'(ioctl_wait), 64'd1);
    check("pend_err", 64'(rom_error), 64'd1);
    @(posedge clk); #1 dn_ready = 1'b1;
    for (int i = 0; i < 60 && core_reset; i++) cyc(1);
    check("pend_fall_release", 64'(core_reset), 64'd0);
    check("pend_fall_sum", 64'(rom_sum), exp_sum());
    check("pend_fall_q", 64'(exp_q.size()), 64'd0);

    // randomised bytes with random stalls
    start_dl();
    for (int i = 0; i < 8; i++) begin
      hps_wr(IDX_ROM, 25'($urandom_range(0, 16383)), 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1);
    end
    cyc(3);
    check("rand_sum", 64'(rom_sum), exp_sum());
    check("rand_cnt", 64'(rom_count), exp_cnt());
    end_dl();

    // reset while a write is pending
    start_dl();
    @(posedge clk); #1;
    ioctl_addr = 25'd20; ioctl_dout = 8'hAB; ioctl_wr = 1'b1; dn_ready = 1'b0;
    @(posedge clk); #1 ioctl_wr = 1'b0;
    @(negedge clk);
    check("pre_rst_state", 64'(dbg_state), 64'(ST_PEND));
    @(posedge clk); #1 reset = 1'b1; ioctl_download = 1'b0;
    cyc(1);
    @(negedge clk);
    check_reset_vals("pend_rst");
    for (int i = 0; i < 8; i++) dip_m[i] = '0;
    @(posedge clk); #1 reset = 1'b0; dn_ready = 1'b1;
    cyc(6);
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("post_rst_dn_data", 64'(dn_data), 64'd0);

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
